// File: rtl/systolic_sequencer_if.sv
// Operand width package plus the sequencer's bus bundle; the sequencer drives
// the array edges and read strobes, the surrounding top level owns the rest.
package matrix_pkg;
  parameter int indata_size = 8;
endpackage

interface systolic_sequencer_if #(
  parameter int N  = 4,
  parameter int KW = 8
);
  localparam int W = matrix_pkg::indata_size;

  logic          start;
  logic [KW-1:0] cfg_k;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [KW-1:0] rd_k;
  logic [N*W-1:0] a_col_data;
  logic [N*W-1:0] b_row_data;
  logic [N*W-1:0] arr_a;
  logic [N*W-1:0] arr_b;
  logic          arr_clear;

  modport master (
    input  start, cfg_k, a_col_data, b_row_data,
    output busy, done, rd_en, rd_k, arr_a, arr_b, arr_clear
  );

  modport slave (
    output start, cfg_k, a_col_data, b_row_data,
    input  busy, done, rd_en, rd_k, arr_a, arr_b, arr_clear
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Sequences one output-stationary C = A*B on an NxN systolic array: clear,
// stream K operand slices onto skewed array edges, drain, then pulse done.
module systolic_sequencer #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_sequencer_if.master bus
);
  localparam int W  = matrix_pkg::indata_size;
  localparam int CW = $clog2((2 ** KW) + 2 * N);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [KW-1:0]  r_K;
  logic [KW-1:0]  r_kIdx;
  logic [CW-1:0]  r_cyc;
  logic [CW-1:0]  w_lastTerm;
  logic           r_dvalid;
  logic           w_busy;
  logic           w_done;
  logic           w_rdEn;
  logic [KW-1:0]  w_rdK;
  logic           w_clear;
  logic [N-1:0][W-1:0] w_gateA;
  logic [N-1:0][W-1:0] w_gateB;
  logic [N-1:0][W-1:0] w_edgeA;
  logic [N-1:0][W-1:0] w_edgeB;

  // r_cyc equals n during cycle cn, so the last PE term lands when it hits K+2N
  assign w_lastTerm = CW'(r_K) + CW'(2 * N);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_K == '0) ? S_DONE : S_FEED;
      S_FEED:  if (r_kIdx == r_K - KW'(1)) w_next = S_DRAIN;
      S_DRAIN: if (r_cyc == w_lastTerm) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_rdEn  = 1'b0;
    w_rdK   = '0;
    w_clear = 1'b0;
    case (r_state)
      S_CLEAR: begin w_busy = 1'b1; w_clear = 1'b1; end
      S_FEED:  begin w_busy = 1'b1; w_rdEn = 1'b1; w_rdK = r_kIdx; end
      S_DRAIN: w_busy = 1'b1;
      S_DONE:  begin w_busy = 1'b1; w_done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_K    <= '0;
      r_kIdx <= '0;
      r_cyc  <= '0;
    end else if (r_state == S_IDLE) begin
      r_cyc  <= CW'(1);
      r_kIdx <= '0;
      if (bus.start) r_K <= bus.cfg_k;
    end else begin
      r_cyc <= r_cyc + CW'(1);
      if (r_state == S_FEED) r_kIdx <= r_kIdx + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_dvalid <= 1'b0;
    else       r_dvalid <= w_rdEn;
  end

  // Gating keeps the edges at zero outside the stream so finished PEs only add 0*0
  assign w_gateA = r_dvalid ? bus.a_col_data : '0;
  assign w_gateB = r_dvalid ? bus.b_row_data : '0;

  for (genvar g = 0; g < N; g++) begin : g_skew
    if (g == 0) begin : g_direct
      assign w_edgeA[g] = w_gateA[g];
      assign w_edgeB[g] = w_gateB[g];
    end else begin : g_pipe
      logic [W-1:0] r_pa [g];
      logic [W-1:0] r_pb [g];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < g; s++) begin
            r_pa[s] <= '0;
            r_pb[s] <= '0;
          end
        end else begin
          r_pa[0] <= w_gateA[g];
          r_pb[0] <= w_gateB[g];
          for (int s = 1; s < g; s++) begin
            r_pa[s] <= r_pa[s-1];
            r_pb[s] <= r_pb[s-1];
          end
        end
      end

      assign w_edgeA[g] = r_pa[g-1];
      assign w_edgeB[g] = r_pb[g-1];
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.rd_en     = w_rdEn;
  assign bus.rd_k      = w_rdK;
  assign bus.arr_clear = w_clear;
  assign bus.arr_a     = w_edgeA;
  assign bus.arr_b     = w_edgeB;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: models the operand buffers and the PE grid,
// and predicts every output per cycle from the run's timing rules.
module tb_systolic_sequencer;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int W  = matrix_pkg::indata_size;

  logic clk = 1'b0;
  logic reset;

  systolic_sequencer_if #(.N(N), .KW(KW)) bus ();

  systolic_sequencer #(.N(N), .KW(KW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic signed [W-1:0] memA [N][256];
  logic signed [W-1:0] memB [256][N];

  typedef struct {
    int k;
    int pattern;
    int resetAt;
    int expDone;
  } runVec_t;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Operand buffer: read data appears exactly one cycle after rd_en, junk otherwise
  initial begin
    bit rv;
    int rk;
    bus.a_col_data = '0;
    bus.b_row_data = '0;
    forever begin
      @(negedge clk);
      rv = bus.rd_en;
      rk = int'(bus.rd_k);
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        bus.a_col_data[i*W +: W] = rv ? memA[i][rk] : W'($urandom);
        bus.b_row_data[i*W +: W] = rv ? memB[rk][i] : W'($urandom);
      end
    end
  end

  // Output-stationary PE grid: A moves right, B moves down, one register per hop
  logic signed [W-1:0]   pa  [N][N];
  logic signed [W-1:0]   pb  [N][N];
  logic signed [4*W-1:0] acc [N][N];

  function automatic logic signed [W-1:0] peInA(int i, int j);
    return (j == 0) ? $signed(bus.arr_a[i*W +: W]) : pa[i][j-1];
  endfunction

  function automatic logic signed [W-1:0] peInB(int i, int j);
    return (i == 0) ? $signed(bus.arr_b[j*W +: W]) : pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || bus.arr_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + peInA(i, j) * peInB(i, j);
          pa[i][j]  <= peInA(i, j);
          pb[i][j]  <= peInB(i, j);
        end
      end
    end
  end

  task automatic fillOperands(input int pattern);
    for (int kk = 0; kk < 256; kk++) begin
      for (int i = 0; i < N; i++) begin
        case (pattern)
          0: begin
            memA[i][kk] = (i == kk) ? W'(1) : W'(0);
            memB[kk][i] = W'(4 * kk + i + 1);
          end
          1: begin
            memA[i][kk] = W'(10 * i + kk + 1);
            memB[kk][i] = W'($urandom);
          end
          2: begin
            memA[i][kk] = W'(-128);
            memB[kk][i] = W'(-128);
          end
          default: begin
            memA[i][kk] = W'($urandom);
            memB[kk][i] = W'($urandom);
          end
        endcase
      end
    end
  endtask

  function automatic longint refC(int i, int j, int k);
    longint s = 0;
    for (int kk = 0; kk < k; kk++) s += longint'(memA[i][kk]) * longint'(memB[kk][j]);
    return s;
  endfunction

  task automatic applyStimulus(input runVec_t v, input bit hold, input bit chained);
    int  doneC, lastN, doneAt, doneCnt, kk;
    bit  live;
    longint expA, expB;
    fillOperands(v.pattern);
    doneC = (v.k == 0) ? 2 : v.k + 2 * N + 1;
    lastN = doneC + 1;
    if (!chained) begin
      @(posedge clk);
      #1;
      bus.start = 1'b1;
    end
    bus.cfg_k = KW'(v.k);
    if (!chained) @(negedge clk);
    doneAt  = 0;
    doneCnt = 0;
    for (int n = 1; n <= lastN; n++) begin
      @(negedge clk);
      live = (v.resetAt == 0) || (n <= v.resetAt);
      if (bus.done) begin
        doneCnt++;
        if (doneAt == 0) doneAt = n;
      end
      checkOutput($sformatf("busy K=%0d c%0d", v.k, n), bus.busy, live && n <= doneC);
      checkOutput($sformatf("done K=%0d c%0d", v.k, n), bus.done, live && n == doneC);
      checkOutput($sformatf("arr_clear K=%0d c%0d", v.k, n), bus.arr_clear, live && n == 1);
      checkOutput($sformatf("rd_en K=%0d c%0d", v.k, n), bus.rd_en, live && n >= 2 && n <= v.k + 1);
      checkOutput($sformatf("rd_k K=%0d c%0d", v.k, n), bus.rd_k,
                  (live && n >= 2 && n <= v.k + 1) ? n - 2 : 0);
      for (int i = 0; i < N; i++) begin
        kk   = n - 3 - i;
        expA = (live && kk >= 0 && kk < v.k) ? longint'(memA[i][kk]) : 0;
        expB = (live && kk >= 0 && kk < v.k) ? longint'(memB[kk][i]) : 0;
        checkOutput($sformatf("arr_a[%0d] K=%0d c%0d", i, v.k, n),
                    longint'($signed(bus.arr_a[i*W +: W])), expA);
        checkOutput($sformatf("arr_b[%0d] K=%0d c%0d", i, v.k, n),
                    longint'($signed(bus.arr_b[i*W +: W])), expB);
      end
      if (n == 1 && !hold) bus.start = 1'b0;
      if (n == 2) bus.cfg_k = KW'($urandom);
      if (v.resetAt != 0 && n == v.resetAt) reset = 1'b1;
      if (v.resetAt != 0 && n == v.resetAt + 1) reset = 1'b0;
    end
    checkOutput($sformatf("done cycle K=%0d", v.k), doneAt, v.expDone);
    checkOutput($sformatf("done count K=%0d", v.k), doneCnt, (v.expDone != 0) ? 1 : 0);
    if (v.resetAt == 0) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          checkOutput($sformatf("C[%0d][%0d] K=%0d", i, j, v.k), longint'(acc[i][j]), refC(i, j, v.k));
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, bus.busy, 0);
    checkOutput({tag, " done"}, bus.done, 0);
    checkOutput({tag, " rd_en"}, bus.rd_en, 0);
    checkOutput({tag, " rd_k"}, bus.rd_k, 0);
    checkOutput({tag, " arr_clear"}, bus.arr_clear, 0);
    checkOutput({tag, " arr_a"}, bus.arr_a, 0);
    checkOutput({tag, " arr_b"}, bus.arr_b, 0);
  endtask

  initial begin
    runVec_t vecs [8];
    runVec_t holdA, holdB;
    vecs[0] = '{k: 4,   pattern: 0, resetAt: 0, expDone: 13};
    vecs[1] = '{k: 4,   pattern: 1, resetAt: 0, expDone: 13};
    vecs[2] = '{k: 0,   pattern: 3, resetAt: 0, expDone: 2};
    vecs[3] = '{k: 1,   pattern: 3, resetAt: 0, expDone: 10};
    vecs[4] = '{k: 4,   pattern: 3, resetAt: 4, expDone: 0};
    vecs[5] = '{k: 4,   pattern: 3, resetAt: 0, expDone: 13};
    vecs[6] = '{k: 7,   pattern: 3, resetAt: 0, expDone: 16};
    vecs[7] = '{k: 255, pattern: 2, resetAt: 0, expDone: 264};
    holdA   = '{k: 4,   pattern: 3, resetAt: 0, expDone: 13};
    holdB   = '{k: 3,   pattern: 1, resetAt: 0, expDone: 12};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.cfg_k = '0;
    fillOperands(3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdle("in reset");
    reset = 1'b0;
    @(negedge clk);
    checkIdle("after reset");

    for (int v = 0; v < 8; v++) begin
      $display("[TB] run %0d: K=%0d pattern=%0d", v, vecs[v].k, vecs[v].pattern);
      applyStimulus(vecs[v], 1'b0, 1'b0);
    end

    $display("[TB] back-to-back runs with start held high");
    applyStimulus(holdA, 1'b1, 1'b0);
    applyStimulus(holdB, 1'b1, 1'b1);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("after held start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
